// File: rtl/icache_loader_if.sv
// rtl/icache_loader_if.sv - byte-stream input and cache write port bundle for icache_loader
interface icache_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        start;
    logic        write;
    logic [31:0] instruction_index;
    logic [15:0] instruction;
    logic        cpu_not_enable;
    logic        done;
    logic        error;

    modport master (
        output rx_valid, rx_data, start,
        input  write, instruction_index, instruction, cpu_not_enable, done, error
    );

    modport slave (
        input  rx_valid, rx_data, start,
        output write, instruction_index, instruction, cpu_not_enable, done, error
    );
endinterface

// File: rtl/icache_loader.sv
// rtl/icache_loader.sv - framed byte-stream loader that fills the instruction cache
module icache_loader #(
    parameter int DEPTH          = 128,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    icache_loader_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [7:0]  lo_q;
    logic [7:0]  csum_q;
    logic [15:0] wr_count_q;
    logic [TW-1:0] timer_q;
    logic        write_q;
    logic [31:0] index_q;
    logic [15:0] instr_q;
    logic        done_c, error_c, cpu_ne_c;

    logic        active;
    logic        timeout;
    logic        last_instr;
    logic [15:0] len_word;

    // The idle timer only matters while a frame is partially received.
    assign active     = (state_q == S_LEN_HI) || (state_q == S_DATA_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_CHECK);
    assign timeout    = active && !bus.rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign len_word   = {bus.rx_data, len_lo_q};
    assign last_instr = (wr_count_q + 16'd1) == len_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_LEN_LO;
        else        state_q <= state_d;
    end

    // Next-state and status outputs; start beats a timeout, which beats a byte.
    always_comb begin
        state_d  = state_q;
        done_c   = (state_q == S_DONE);
        error_c  = (state_q == S_ERROR);
        cpu_ne_c = (state_q != S_DONE);
        if (bus.start) begin
            state_d = S_LEN_LO;
        end else if (timeout) begin
            state_d = S_ERROR;
        end else if (bus.rx_valid) begin
            case (state_q)
                S_LEN_LO:  state_d = S_LEN_HI;
                S_LEN_HI: begin
                    if (len_word > 16'(DEPTH))  state_d = S_ERROR;
                    else if (len_word == 16'd0) state_d = S_CHECK;
                    else                        state_d = S_DATA_LO;
                end
                S_DATA_LO: state_d = S_DATA_HI;
                S_DATA_HI: state_d = last_instr ? S_CHECK : S_DATA_LO;
                S_CHECK:   state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
                default:   state_d = state_q;
            endcase
        end
    end

    // Datapath: length, checksum, idle timer and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            lo_q       <= '0;
            csum_q     <= '0;
            wr_count_q <= '0;
            timer_q    <= '0;
            write_q    <= 1'b0;
            index_q    <= '0;
            instr_q    <= '0;
        end else if (bus.start) begin
            csum_q     <= '0;
            wr_count_q <= '0;
            timer_q    <= '0;
            write_q    <= 1'b0;
            index_q    <= '0;
        end else begin
            write_q <= 1'b0;
            if (active && !bus.rx_valid && !timeout) timer_q <= timer_q + 1'b1;
            else                                     timer_q <= '0;
            if (bus.rx_valid) begin
                case (state_q)
                    S_LEN_LO:  len_lo_q <= bus.rx_data;
                    S_LEN_HI:  len_q    <= len_word;
                    S_DATA_LO: begin
                        lo_q   <= bus.rx_data;
                        csum_q <= csum_q ^ bus.rx_data;
                    end
                    S_DATA_HI: begin
                        csum_q     <= csum_q ^ bus.rx_data;
                        write_q    <= 1'b1;
                        instr_q    <= {bus.rx_data, lo_q};
                        // Index only moves when a new write is issued, so it
                        // stays stable between writes for the cache's sampling.
                        index_q    <= {16'd0, wr_count_q};
                        wr_count_q <= wr_count_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A start arriving while a write is on the port cancels that write.
    assign bus.write             = write_q & ~bus.start;
    assign bus.instruction_index = index_q;
    assign bus.instruction       = instr_q;
    assign bus.done              = done_c;
    assign bus.error             = error_c;
    assign bus.cpu_not_enable    = cpu_ne_c;
endmodule

// File: tb/tb_icache_loader.sv
// tb/tb_icache_loader.sv - randomized self-checking bench for icache_loader
module tb_icache_loader;
    localparam int DEPTH   = 128;
    localparam int TIMEOUT = 16;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    icache_loader_if bus();

    icache_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] cap_idx[$];
    logic [15:0] cap_ins[$];

    // Record every cache write the way the cache sees it: at the negedge.
    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            cap_idx.push_back(bus.instruction_index);
            cap_ins.push_back(bus.instruction);
        end
    end

    logic [15:0] exp_ins[$];
    logic        exp_done;
    logic        exp_err;

    // Frame-level reference: what writes and outcome a byte list should produce.
    function automatic void model_frame(input byte_q_t bs);
        int n;
        logic [7:0] cs;
        exp_ins.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        cs = 8'h00;
        if (bs.size() < 2) return;
        n = {bs[1], bs[0]};
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (3 + 2 * i >= bs.size()) return;
            exp_ins.push_back({bs[3 + 2 * i], bs[2 + 2 * i]});
            cs = cs ^ bs[2 + 2 * i] ^ bs[3 + 2 * i];
        end
        if (bs.size() > 2 + 2 * n) begin
            if (bs[2 + 2 * n] == cs) exp_done = 1'b1;
            else                     exp_err  = 1'b1;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cap_idx.delete();
        cap_ins.delete();
    endtask

    task automatic test_reset();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus.write); end
        checks++; if (bus.instruction_index !== 32'd0) begin errors++; $display("FAIL reset_index got %0d want 0", bus.instruction_index); end
        checks++; if (bus.instruction !== 16'd0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instruction); end
        checks++; if (bus.cpu_not_enable !== 1'b1) begin errors++; $display("FAIL reset_cne got %b want 1", bus.cpu_not_enable); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
    endtask

    task automatic test_basic();
        logic [7:0] cs;
        cs = 8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56;
        drive_byte(8'h02); drive_byte(8'h00); drive_byte(8'h34); drive_byte(8'h12);
        checks++; if ({bus.write, bus.instruction_index, bus.instruction} !== {1'b1, 32'd0, 16'h1234}) begin
            errors++; $display("FAIL basic_w0 got w=%b idx=%0d ins=%h want w=1 idx=0 ins=1234", bus.write, bus.instruction_index, bus.instruction); end
        drive_byte(8'h78);
        checks++; if ({bus.write, bus.instruction_index, bus.instruction} !== {1'b0, 32'd0, 16'h1234}) begin
            errors++; $display("FAIL basic_hold got w=%b idx=%0d ins=%h want w=0 idx=0 ins=1234", bus.write, bus.instruction_index, bus.instruction); end
        drive_byte(8'h56);
        checks++; if ({bus.write, bus.instruction_index, bus.instruction} !== {1'b1, 32'd1, 16'h5678}) begin
            errors++; $display("FAIL basic_w1 got w=%b idx=%0d ins=%h want w=1 idx=1 ins=5678", bus.write, bus.instruction_index, bus.instruction); end
        drive_byte(cs);
        idle(2);
        checks++; if ({bus.done, bus.cpu_not_enable, bus.error} !== 3'b100) begin
            errors++; $display("FAIL basic_status got done/cne/err=%b want 100", {bus.done, bus.cpu_not_enable, bus.error}); end
        checks++; if (cap_idx.size() !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", cap_idx.size()); end
    endtask

    task automatic test_bad_checksum();
        do_start();
        drive_byte(8'h02); drive_byte(8'h00); drive_byte(8'h34); drive_byte(8'h12);
        drive_byte(8'h78); drive_byte(8'h56); drive_byte(8'h00);
        idle(1);
        checks++; if (cap_idx.size() !== 2) begin errors++; $display("FAIL badcs_count got %0d want 2", cap_idx.size()); end
        checks++; if ({bus.done, bus.cpu_not_enable, bus.error} !== 3'b011) begin
            errors++; $display("FAIL badcs_status got done/cne/err=%b want 011", {bus.done, bus.cpu_not_enable, bus.error}); end
    endtask

    task automatic test_oversize();
        do_start();
        drive_byte(8'h81); drive_byte(8'h00);
        checks++; if ({bus.error, bus.write} !== 2'b10) begin
            errors++; $display("FAIL oversize got err/write=%b want 10", {bus.error, bus.write}); end
        drive_byte(8'h11); drive_byte(8'h22);
        idle(1);
        checks++; if (cap_idx.size() !== 0) begin errors++; $display("FAIL oversize_count got %0d want 0", cap_idx.size()); end
    endtask

    task automatic test_empty_then_one();
        do_start();
        drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h00);
        checks++; if ({bus.done, bus.cpu_not_enable, bus.error, bus.write} !== 4'b1000) begin
            errors++; $display("FAIL empty got done/cne/err/w=%b want 1000", {bus.done, bus.cpu_not_enable, bus.error, bus.write}); end
        do_start();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL start_clears_done got %b want 0", bus.done); end
        drive_byte(8'h01); drive_byte(8'h00); drive_byte(8'hCD); drive_byte(8'hAB);
        checks++; if ({bus.write, bus.instruction_index, bus.instruction} !== {1'b1, 32'd0, 16'hABCD}) begin
            errors++; $display("FAIL one_w0 got w=%b idx=%0d ins=%h want w=1 idx=0 ins=abcd", bus.write, bus.instruction_index, bus.instruction); end
        drive_byte(8'h66);
        checks++; if ({bus.done, bus.error} !== 2'b10) begin errors++; $display("FAIL one_done got done/err=%b want 10", {bus.done, bus.error}); end
    endtask

    task automatic test_timeout();
        do_start();
        drive_byte(8'h01); drive_byte(8'h00); drive_byte(8'hCD);
        idle(TIMEOUT - 1);
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", bus.error); end
        idle(1);
        checks++; if ({bus.error, bus.cpu_not_enable} !== 2'b11) begin errors++; $display("FAIL timeout got err/cne=%b want 11", {bus.error, bus.cpu_not_enable}); end
        checks++; if (cap_idx.size() !== 0) begin errors++; $display("FAIL timeout_count got %0d want 0", cap_idx.size()); end
        do_start();
        drive_byte(8'h01); drive_byte(8'h00); drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
        checks++; if ({bus.done, bus.error, bus.cpu_not_enable} !== 3'b100) begin
            errors++; $display("FAIL timeout_reload got done/err/cne=%b want 100", {bus.done, bus.error, bus.cpu_not_enable}); end
    endtask

    task automatic test_start_abort();
        do_start();
        drive_byte(8'h04); drive_byte(8'h00);
        drive_byte(8'hA1); drive_byte(8'hA2); drive_byte(8'hB1); drive_byte(8'hB2); drive_byte(8'hC1);
        bus.start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hC2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        checks++; if ({bus.write, bus.instruction_index} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL abort got w=%b idx=%0d want w=0 idx=0", bus.write, bus.instruction_index); end
        checks++; if (cap_idx.size() !== 2) begin errors++; $display("FAIL abort_count got %0d want 2", cap_idx.size()); end
        cap_idx.delete();
        cap_ins.delete();
        drive_byte(8'h02); drive_byte(8'h00); drive_byte(8'h01); drive_byte(8'h02);
        drive_byte(8'h03); drive_byte(8'h04); drive_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
        checks++; if (cap_idx.size() !== 2) begin
            errors++; $display("FAIL after_abort_count got %0d want 2", cap_idx.size());
        end else begin
            checks++; if ({cap_idx[0], cap_ins[0], cap_idx[1], cap_ins[1]} !== {32'd0, 16'h0201, 32'd1, 16'h0403}) begin
                errors++; $display("FAIL after_abort_writes got %0d:%h %0d:%h want 0:0201 1:0403", cap_idx[0], cap_ins[0], cap_idx[1], cap_ins[1]); end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL after_abort_done got %b want 1", bus.done); end
    endtask

    task automatic test_random();
        byte_q_t fr;
        int n;
        int r;
        logic [7:0] cs;
        for (int it = 0; it < 25; it++) begin
            fr.delete();
            r = $urandom_range(0, 9);
            if (r == 0)      n = DEPTH;
            else if (r == 1) n = DEPTH + 1 + $urandom_range(0, 200);
            else             n = $urandom_range(0, 6);
            fr.push_back(n[7:0]);
            fr.push_back(n[15:8]);
            cs = 8'h00;
            if (n <= DEPTH) begin
                for (int k = 0; k < 2 * n; k++) begin
                    fr.push_back(8'($urandom));
                    cs = cs ^ fr[fr.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
                fr.push_back(cs);
            end
            for (int k = 0; k < $urandom_range(0, 2); k++) fr.push_back(8'($urandom));
            model_frame(fr);
            do_start();
            for (int k = 0; k < fr.size(); k++) begin
                drive_byte(fr[k]);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            idle(2);
            checks++;
            if (cap_idx.size() !== exp_ins.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d want %0d", it, cap_idx.size(), exp_ins.size());
            end else begin
                for (int k = 0; k < exp_ins.size(); k++) begin
                    checks++;
                    if ({cap_idx[k], cap_ins[k]} !== {32'(k), exp_ins[k]}) begin
                        errors++; $display("FAIL rand%0d_write%0d got %0d:%h want %0d:%h", it, k, cap_idx[k], cap_ins[k], k, exp_ins[k]);
                    end
                end
            end
            checks++;
            if ({bus.done, bus.error, bus.cpu_not_enable} !== {exp_done, exp_err, ~exp_done}) begin
                errors++; $display("FAIL rand%0d_status got done/err/cne=%b want %b", it, {bus.done, bus.error, bus.cpu_not_enable}, {exp_done, exp_err, ~exp_done});
            end
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.start    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_bad_checksum();
        test_oversize();
        test_empty_then_one();
        test_timeout();
        test_start_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
